// File: rtl/memwb_pipe_reg.sv
// memwb_pipe_reg: MEM/WB pipeline stage with a 2-entry skid buffer,
// load-size extraction/extension and a handshake-qualified writeback port.
//
// Parameters:
//   DATA_W  datapath width (32 or 64)
//   RA_W    register address width
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   flush              drop held entries and the same-cycle input
//   in_valid/in_ready  upstream handshake (in_ready depends on state only)
//   in_read_data       raw load data aligned to bit 0
//   in_alu_result      ALU result
//   in_rd              destination register
//   in_memtoreg        pick load data for writeback
//   in_regwrite        register write enable
//   in_ld_size         0 byte, 1 half, 2 word, 3 double
//   in_ld_unsigned     zero-extend instead of sign-extend
//   out_valid/out_ready downstream handshake for the head entry
//   out_*              head entry fields (hold last value when not valid)
//   wb_we/wb_rd/wb_data register-file write port, also seen by forwarding
//   occupancy          number of held entries (0..2)
module memwb_pipe_reg #(
    parameter int DATA_W = 64,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              in_memtoreg,
    input  logic              in_regwrite,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_readdata,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [RA_W-1:0]   out_rd,
    output logic              out_memtoreg,
    output logic              out_regwrite,
    output logic              wb_we,
    output logic [RA_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        occupancy
);

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
            $error("memwb_pipe_reg: DATA_W must be 32 or 64");
        end
    endgenerate

    // State value doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] readdata;
        logic [DATA_W-1:0] alu;
        logic [RA_W-1:0]   rd;
        logic              memtoreg;
        logic              regwrite;
    } entry_t;

    state_t state;
    state_t state_nxt;

    entry_t head;
    entry_t skid;
    entry_t cap;

    logic accept;
    logic drain;
    logic load_head;
    logic load_skid;
    logic shift;

    // Keep the low bits selected by size; fill the rest with the
    // sign bit or zeros. With DATA_W=32 the word/double masks are
    // all ones, so those sizes pass the data through unchanged.
    function automatic logic [DATA_W-1:0] extract(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [DATA_W-1:0] mask;
        logic              sign;
        mask = '1;
        sign = 1'b0;
        case (size)
            2'd0: begin
                mask = {DATA_W{1'b1}} >> (DATA_W - 8);
                sign = d[7];
            end
            2'd1: begin
                mask = {DATA_W{1'b1}} >> (DATA_W - 16);
                sign = d[15];
            end
            2'd2: begin
                mask = {DATA_W{1'b1}} >> (DATA_W - 32);
                sign = d[31];
            end
            default: begin
                mask = '1;
                sign = d[DATA_W-1];
            end
        endcase
        return (d & mask) | ((!uns && sign) ? ~mask : '0);
    endfunction

    always_comb begin
        cap          = '0;
        cap.readdata = extract(in_read_data, in_ld_size, in_ld_unsigned);
        cap.alu      = in_alu_result;
        cap.rd       = in_rd;
        cap.memtoreg = in_memtoreg;
        cap.regwrite = in_regwrite && (in_rd != '0);
    end

    assign accept = in_valid && in_ready && !flush;
    assign drain  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (accept) state_nxt = ONE;
            end
            ONE: begin
                if (accept && !drain) begin
                    state_nxt = TWO;
                end else if (!accept && drain) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (drain) state_nxt = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    // Output / control decode; everything here depends on state only,
    // except the load strobes, so in_ready never sees out_ready.
    always_comb begin
        in_ready  = (state != TWO);
        out_valid = (state != EMPTY);
        occupancy = state;
        load_head = 1'b0;
        load_skid = 1'b0;
        shift     = 1'b0;
        unique case (state)
            EMPTY: load_head = accept;
            ONE: begin
                load_head = accept && drain;
                load_skid = accept && !drain;
            end
            TWO: shift = drain && !flush;
            default: ;
        endcase
    end

    // Payload storage
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head) begin
                head <= cap;
            end else if (shift) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= cap;
            end else if (shift) begin
                skid <= '0;
            end
        end
    end

    assign out_readdata   = head.readdata;
    assign out_alu_result = head.alu;
    assign out_rd         = head.rd;
    assign out_memtoreg   = head.memtoreg;
    assign out_regwrite   = head.regwrite;

    assign wb_we   = out_valid && out_ready && out_regwrite;
    assign wb_rd   = out_rd;
    assign wb_data = out_memtoreg ? out_readdata : out_alu_result;

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// tb_memwb_pipe_reg: scoreboard bench for memwb_pipe_reg (DATA_W=64).
// Driver pushes expected entries on accept; monitor checks at negedge.
module tb_memwb_pipe_reg;

    typedef struct {
        logic [63:0] rdata;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_read_data = '0;
    logic [63:0] in_alu_result = '0;
    logic [4:0]  in_rd = '0;
    logic        in_memtoreg = 1'b0;
    logic        in_regwrite = 1'b0;
    logic [1:0]  in_ld_size = '0;
    logic        in_ld_unsigned = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_readdata;
    logic [63:0] out_alu_result;
    logic [4:0]  out_rd;
    logic        out_memtoreg;
    logic        out_regwrite;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [1:0]  occupancy;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    bit   pushed_now = 1'b0;
    bit   armed = 1'b0;

    memwb_pipe_reg #(.DATA_W(64), .RA_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_read_data(in_read_data), .in_alu_result(in_alu_result),
        .in_rd(in_rd), .in_memtoreg(in_memtoreg),
        .in_regwrite(in_regwrite), .in_ld_size(in_ld_size),
        .in_ld_unsigned(in_ld_unsigned),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_readdata(out_readdata), .out_alu_result(out_alu_result),
        .out_rd(out_rd), .out_memtoreg(out_memtoreg),
        .out_regwrite(out_regwrite),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference load extension from the size/sign rules.
    function automatic logic [63:0] ext_model(input logic [63:0] d,
                                              input logic [1:0] sz,
                                              input logic u);
        logic s;
        case (sz)
            2'd0: begin
                s = d[7] && !u;
                return {{56{s}}, d[7:0]};
            end
            2'd1: begin
                s = d[15] && !u;
                return {{48{s}}, d[15:0]};
            end
            2'd2: begin
                s = d[31] && !u;
                return {{32{s}}, d[31:0]};
            end
            default: return d;
        endcase
    endfunction

    task automatic step(input bit v, input logic [63:0] rdat,
                        input logic [63:0] alu, input logic [4:0] rd,
                        input bit m2r, input bit rw, input logic [1:0] sz,
                        input bit uns, input bit ordy, input bit fl,
                        input bit rst);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid       = v;
        in_read_data   = rdat;
        in_alu_result  = alu;
        in_rd          = rd;
        in_memtoreg    = m2r;
        in_regwrite    = rw;
        in_ld_size     = sz;
        in_ld_unsigned = uns;
        out_ready      = ordy;
        flush          = fl;
        reset          = rst;
        pushed_now     = 1'b0;
        if (v && in_ready && !fl && !rst) begin
            e.rdata = ext_model(rdat, sz, uns);
            e.alu   = alu;
            e.rd    = rd;
            e.m2r   = m2r;
            e.rw    = rw && (rd != 5'd0);
            exp_q.push_back(e);
            pushed_now = 1'b1;
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0, ordy, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
        chk({tag, "_readdata"}, out_readdata, 64'd0);
        chk({tag, "_alu"}, out_alu_result, 64'd0);
        chk({tag, "_rd"}, 64'(out_rd), 64'd0);
        chk({tag, "_memtoreg"}, 64'(out_memtoreg), 64'd0);
        chk({tag, "_regwrite"}, 64'(out_regwrite), 64'd0);
        chk({tag, "_wb_we"}, 64'(wb_we), 64'd0);
        chk({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
        chk({tag, "_wb_data"}, wb_data, 64'd0);
    endtask

    // Monitor / scoreboard
    int   held;
    exp_t h;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            armed = 1'b1;
        end else if (armed) begin
            held = exp_q.size() - int'(pushed_now);
            chk("occupancy", 64'(occupancy), 64'(held));
            chk("out_valid", 64'(out_valid), 64'(held != 0));
            chk("in_ready", 64'(in_ready), 64'(held < 2));
            if (held != 0) begin
                h = exp_q[0];
                chk("head_readdata", out_readdata, h.rdata);
                chk("head_alu", out_alu_result, h.alu);
                chk("head_rd", 64'(out_rd), 64'(h.rd));
                chk("head_memtoreg", 64'(out_memtoreg), 64'(h.m2r));
                chk("head_regwrite", 64'(out_regwrite), 64'(h.rw));
                chk("wb_we", 64'(wb_we), 64'(out_ready && h.rw));
                chk("wb_rd", 64'(wb_rd), 64'(h.rd));
                chk("wb_data", wb_data, h.m2r ? h.rdata : h.alu);
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                chk("wb_we_idle", 64'(wb_we), 64'd0);
            end
            if (flush) exp_q.delete();
        end
    end

    initial begin
        // reset
        step(0, '0, '0, '0, 0, 0, 0, 0, 0, 0, 1);
        step(0, '0, '0, '0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_zero("reset");

        // single entry, immediate writeback
        step(1, '0, 64'h1234, 5'd3, 0, 1, 0, 0, 1, 0, 0);
        idle(1);
        @(negedge clk);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_wb_we", 64'(wb_we), 64'd1);
        chk("t1_wb_rd", 64'(wb_rd), 64'd3);
        chk("t1_wb_data", wb_data, 64'h1234);
        idle(1);
        @(negedge clk);
        chk("t1_occ", 64'(occupancy), 64'd0);

        // load extension
        step(1, 64'h80, '0, 5'd4, 1, 1, 2'd0, 0, 0, 0, 0);
        idle(0);
        @(negedge clk);
        chk("ext_b_s", out_readdata, 64'hFFFF_FFFF_FFFF_FF80);
        step(1, 64'h80, '0, 5'd4, 1, 1, 2'd0, 1, 1, 0, 0);
        idle(1);
        @(negedge clk);
        chk("ext_b_u", out_readdata, 64'h80);
        step(1, 64'h8000_0000, '0, 5'd6, 1, 1, 2'd2, 0, 0, 0, 0);
        idle(0);
        @(negedge clk);
        chk("ext_w_s", out_readdata, 64'hFFFF_FFFF_8000_0000);
        idle(1);
        idle(1);

        // backpressure A, B, C
        step(1, '0, 64'hA, 5'd1, 0, 1, 0, 0, 0, 0, 0);
        step(1, '0, 64'hB, 5'd2, 0, 1, 0, 0, 0, 0, 0);
        step(1, '0, 64'hC, 5'd3, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_occ", 64'(occupancy), 64'd2);
        chk("bp_head", out_alu_result, 64'hA);
        step(1, '0, 64'hC, 5'd3, 0, 1, 0, 0, 1, 0, 0);
        step(1, '0, 64'hC, 5'd3, 0, 1, 0, 0, 1, 0, 0);
        idle(1);
        idle(1);
        @(negedge clk);
        chk("bp_drained", 64'(occupancy), 64'd0);

        // x0 suppression
        step(1, '0, 64'hDEAD, 5'd0, 0, 1, 0, 0, 0, 0, 0);
        idle(0);
        @(negedge clk);
        chk("x0_valid", 64'(out_valid), 64'd1);
        chk("x0_regwrite", 64'(out_regwrite), 64'd0);
        idle(1);
        @(negedge clk);
        chk("x0_wb_we", 64'(wb_we), 64'd0);
        idle(1);

        // flush at occupancy 2 with input pending
        step(1, '0, 64'h11, 5'd7, 0, 1, 0, 0, 0, 0, 0);
        step(1, '0, 64'h22, 5'd8, 0, 1, 0, 0, 0, 0, 0);
        step(1, '0, 64'h33, 5'd9, 0, 1, 0, 0, 1, 1, 0);
        @(negedge clk);
        chk("fl_wb_we", 64'(wb_we), 64'd1);
        chk("fl_wb_data", wb_data, 64'h11);
        idle(1);
        @(negedge clk);
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);

        // flush with room: input must be discarded
        step(1, '0, 64'h44, 5'd10, 0, 1, 0, 0, 1, 1, 0);
        idle(1);
        @(negedge clk);
        chk("fl1_valid", 64'(out_valid), 64'd0);

        // reset + flush at occupancy 2
        step(1, '0, 64'h55, 5'd11, 1, 1, 2'd3, 0, 0, 0, 0);
        step(1, '0, 64'h66, 5'd12, 0, 1, 0, 0, 0, 0, 0);
        step(1, '0, 64'h77, 5'd13, 0, 1, 0, 0, 1, 1, 1);
        idle(1);
        @(negedge clk);
        chk_zero("rst2");
        idle(1);
        idle(1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 60,
                 {$urandom, $urandom}, {$urandom, $urandom},
                 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
                 2'($urandom), 1'($urandom),
                 $urandom_range(0, 99) < 65,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 199) < 1);
        end
        idle(1);
        idle(1);
        idle(1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
